dmem_arbiter: RTL

- Shares the single-port data memory between two requesters.
  - Port C: the pipeline MEM stage (CPU).
  - Port D: the debug/program-loader interface.
- Fixed priority to the CPU, with a starvation counter that guarantees debug progress and a debug lock that halts CPU access.
- Sits between the MEM stage and the DMEM instance and drives DMEM write-enable, address and write data.
- Returns read data to the owning port and raises a stall towards the pipeline hazard logic.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, debug port and DMEM port seen by dmem_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus DMEM.
interface dmem_arbiter_if #(
    parameter int REG_WIDTH = 32
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [REG_WIDTH-1:0] cpu_addr;
    logic [REG_WIDTH-1:0] cpu_wdata;
    logic                 cpu_gnt;
    logic                 cpu_rvalid;
    logic [REG_WIDTH-1:0] cpu_rdata;
    logic                 cpu_stall;

    logic                 dbg_req;
    logic                 dbg_we;
    logic [REG_WIDTH-1:0] dbg_addr;
    logic [REG_WIDTH-1:0] dbg_wdata;
    logic                 dbg_lock;
    logic                 dbg_gnt;
    logic                 dbg_rvalid;
    logic [REG_WIDTH-1:0] dbg_rdata;

    logic                 mem_wr_en;
    logic [REG_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0] mem_wr_data;
    logic [REG_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_wr_en, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_wr_en, mem_addr, mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: CPU has fixed priority, a starvation counter forces
// debug through after STARVE_LIMIT denied cycles, and dbg_lock fences the CPU off.
module dmem_arbiter #(
    parameter int REG_WIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,   // active-high despite the name
    dmem_arbiter_if.slave   bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

    logic [3:0]           starve_cnt_q, starve_cnt_d;
    logic                 rsp_pend_q,   rsp_pend_d;
    owner_e               rsp_owner_q,  rsp_owner_d;
    logic [REG_WIDTH-1:0] addr_q,       addr_d;
    logic [REG_WIDTH-1:0] wdata_q,      wdata_d;
    logic [REG_WIDTH-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [REG_WIDTH-1:0] dbg_rdata_q,  dbg_rdata_d;

    logic                 cpu_gnt;
    logic                 dbg_gnt;
    logic                 cpu_rvalid;
    logic                 dbg_rvalid;

    // Grant decision uses only requests, lock and the counter, never mem_rd_data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset_n) begin
            if (bus.dbg_lock) begin
                dbg_gnt = bus.dbg_req;
            end else if (bus.dbg_req && starve_cnt_q == LIMIT) begin
                dbg_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (bus.dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        starve_cnt_d = '0;
        if (bus.dbg_req && !dbg_gnt) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end

        rsp_pend_d  = (cpu_gnt && !bus.cpu_we) || (dbg_gnt && !bus.dbg_we);
        rsp_owner_d = dbg_gnt ? OWNER_DBG : OWNER_CPU;

        // Keep a copy of whatever was last presented so idle cycles hold the bus.
        addr_d      = bus.mem_addr;
        wdata_d     = bus.mem_wr_data;
        cpu_rdata_d = bus.cpu_rdata;
        dbg_rdata_d = bus.dbg_rdata;
    end

    // Outputs. A response pending when reset arrives is suppressed here.
    always_comb begin
        cpu_rvalid = rsp_pend_q && (rsp_owner_q == OWNER_CPU) && !reset_n;
        dbg_rvalid = rsp_pend_q && (rsp_owner_q == OWNER_DBG) && !reset_n;
    end

    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.dbg_gnt     = dbg_gnt;
    assign bus.cpu_stall   = bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_rvalid  = cpu_rvalid;
    assign bus.dbg_rvalid  = dbg_rvalid;
    assign bus.cpu_rdata   = cpu_rvalid ? bus.mem_rd_data : cpu_rdata_q;
    assign bus.dbg_rdata   = dbg_rvalid ? bus.mem_rd_data : dbg_rdata_q;

    assign bus.mem_wr_en   = (cpu_gnt & bus.cpu_we) | (dbg_gnt & bus.dbg_we);
    assign bus.mem_addr    = cpu_gnt ? bus.cpu_addr  : (dbg_gnt ? bus.dbg_addr  : addr_q);
    assign bus.mem_wr_data = cpu_gnt ? bus.cpu_wdata : (dbg_gnt ? bus.dbg_wdata : wdata_q);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset_n) begin
            starve_cnt_q <= '0;
            rsp_pend_q   <= 1'b0;
            rsp_owner_q  <= OWNER_CPU;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_pend_q   <= rsp_pend_d;
            rsp_owner_q  <= rsp_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end
endmodule
